// File: rtl/stack_pkg.sv
// stack_ctrl shared types: FSM states, grant codes, default sizes.
package stack_pkg;

    localparam int DEPTH_DEF = 4;
    localparam int AW_DEF    = 20;

    typedef enum logic [1:0] {
        IDLE,
        PUSH,
        POP,
        DONE
    } state_t;

    typedef logic [1:0] gnt_t;

    localparam gnt_t GNT_NONE = 2'b00;
    localparam gnt_t GNT_CALL = 2'b01;
    localparam gnt_t GNT_IRQ  = 2'b10;
    localparam gnt_t GNT_RET  = 2'b11;

endpackage

// File: rtl/stack_ctrl_if.sv
// Requester-side bundle of stack_ctrl: push/pop requests and
// grant, completion and occupancy status.
interface stack_ctrl_if import stack_pkg::*; #(
    parameter int AW = AW_DEF
);

    logic          IRQ_REQ;
    logic [AW-1:0] IRQ_ADDR;
    logic          RET_REQ;
    logic          CALL_REQ;
    logic [AW-1:0] CALL_ADDR;
    logic          ERR_CLR;

    logic          ACK;
    logic          NAK;
    gnt_t          GNT;
    logic [AW-1:0] RET_ADDR;
    logic          RET_VLD;
    logic [2:0]    DEPTH_CNT;
    logic          FULL;
    logic          EMPTY;
    logic          ERR;

    modport master (
        output IRQ_REQ, IRQ_ADDR, RET_REQ,
        output CALL_REQ, CALL_ADDR, ERR_CLR,
        input  ACK, NAK, GNT, RET_ADDR, RET_VLD,
        input  DEPTH_CNT, FULL, EMPTY, ERR
    );

    modport slave (
        input  IRQ_REQ, IRQ_ADDR, RET_REQ,
        input  CALL_REQ, CALL_ADDR, ERR_CLR,
        output ACK, NAK, GNT, RET_ADDR, RET_VLD,
        output DEPTH_CNT, FULL, EMPTY, ERR
    );

endinterface

// File: rtl/stack_ctrl_arb.sv
// Fixed-priority arbiter: IRQ > RET > CALL, one-hot grant
// {irq, ret, call}.
module stack_ctrl_arb (
    input  logic       irq_req,
    input  logic       ret_req,
    input  logic       call_req,
    output logic [2:0] gnt
);

    always_comb begin
        gnt = 3'b000;
        priority case (1'b1)
            irq_req:  gnt = 3'b100;
            ret_req:  gnt = 3'b010;
            call_req: gnt = 3'b001;
            default:  gnt = 3'b000;
        endcase
    end

endmodule

// File: rtl/stack_ctrl.sv
// Return-stack controller: arbitrates CALL/IRQ pushes and RET pops.
// Define STACK_CTRL_IRQ_EN to let IRQ_REQ take part in arbitration.
module stack_ctrl import stack_pkg::*; #(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          CLK2,
    input  logic          RST,
    stack_ctrl_if.slave   bus,
    input  logic [AW-1:0] STK_DO,
    output logic          STK_ENA,
    output logic          STK_RTS,
    output logic [AW-1:0] STK_DI
);

    state_t        state_q, state_d;
    logic          ena_q, ena_d;
    logic          rts_q, rts_d;
    logic [AW-1:0] di_q, di_d;
    logic          ack_q, ack_d;
    logic          nak_q, nak_d;
    gnt_t          gnt_q, gnt_d;
    logic [AW-1:0] ret_q, ret_d;
    logic          vld_q, vld_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          err_q, err_d;

    logic          irq_req;
    logic [2:0]    arb_gnt;

`ifdef STACK_CTRL_IRQ_EN
    assign irq_req = bus.IRQ_REQ;
`else
    logic unused_irq;
    assign irq_req    = 1'b0;
    assign unused_irq = bus.IRQ_REQ;
`endif

    stack_ctrl_arb u_arb (
        .irq_req  (irq_req),
        .ret_req  (bus.RET_REQ),
        .call_req (bus.CALL_REQ),
        .gnt      (arb_gnt)
    );

    always_comb begin
        state_d = state_q;
        ena_d   = 1'b0;
        rts_d   = 1'b0;
        ack_d   = 1'b0;
        nak_d   = 1'b0;
        vld_d   = 1'b0;
        di_d    = di_q;
        gnt_d   = gnt_q;
        ret_d   = ret_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (bus.ERR_CLR)
            err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                gnt_d = GNT_NONE;
                unique case (1'b1)
                    arb_gnt[2], arb_gnt[0]: begin
                        if (full_q) begin
                            nak_d = 1'b1;
                            err_d = 1'b1;
                        end else begin
                            state_d = PUSH;
                            gnt_d   = arb_gnt[2] ? GNT_IRQ : GNT_CALL;
                            di_d    = arb_gnt[2] ? bus.IRQ_ADDR
                                                 : bus.CALL_ADDR;
                        end
                    end
                    arb_gnt[1]: begin
                        if (empty_q) begin
                            nak_d = 1'b1;
                            err_d = 1'b1;
                        end else begin
                            state_d = POP;
                            gnt_d   = GNT_RET;
                        end
                    end
                    default: ;
                endcase
            end
            PUSH: begin
                ena_d   = 1'b1;
                ack_d   = 1'b1;
                cnt_d   = cnt_q + 3'd1;
                state_d = IDLE;
            end
            // Top of stack is captured before the pop strobe takes effect.
            POP: begin
                rts_d   = 1'b1;
                ret_d   = STK_DO;
                cnt_d   = cnt_q - 3'd1;
                state_d = DONE;
            end
            DONE: begin
                vld_d   = 1'b1;
                ack_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        full_d  = (cnt_d == 3'(DEPTH));
        empty_d = (cnt_d == 3'd0);
    end

    always_ff @(posedge CLK2 or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            ena_q   <= 1'b0;
            rts_q   <= 1'b0;
            di_q    <= '0;
            ack_q   <= 1'b0;
            nak_q   <= 1'b0;
            gnt_q   <= GNT_NONE;
            ret_q   <= '0;
            vld_q   <= 1'b0;
            cnt_q   <= 3'd0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ena_q   <= ena_d;
            rts_q   <= rts_d;
            di_q    <= di_d;
            ack_q   <= ack_d;
            nak_q   <= nak_d;
            gnt_q   <= gnt_d;
            ret_q   <= ret_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            err_q   <= err_d;
        end
    end

    assign STK_ENA       = ena_q;
    assign STK_RTS       = rts_q;
    assign STK_DI        = di_q;
    assign bus.ACK       = ack_q;
    assign bus.NAK       = nak_q;
    assign bus.GNT       = gnt_q;
    assign bus.RET_ADDR  = ret_q;
    assign bus.RET_VLD   = vld_q;
    assign bus.DEPTH_CNT = cnt_q;
    assign bus.FULL      = full_q;
    assign bus.EMPTY     = empty_q;
    assign bus.ERR       = err_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Self-checking bench for stack_ctrl: vector table, scoreboarded
// push/pop data, and hand-written reset/error/arbitration sequences.
module tb_stack_ctrl;
    import stack_pkg::*;

    localparam int AW = 20;

    typedef struct {
        int            kind;
        logic [AW-1:0] addr;
        logic          exp_ack;
        gnt_t          exp_gnt;
        logic [2:0]    exp_cnt;
        logic          exp_err;
        logic [AW-1:0] exp_ret;
    } vec_t;

    logic          CLK2 = 1'b0;
    logic          RST;
    logic [AW-1:0] STK_DO;
    logic [AW-1:0] STK_DI;
    logic          STK_ENA;
    logic          STK_RTS;

    always #5 CLK2 = ~CLK2;

    stack_ctrl_if #(.AW(AW)) bus ();

    stack_ctrl #(.DEPTH(4), .AW(AW)) dut (
        .CLK2    (CLK2),
        .RST     (RST),
        .bus     (bus),
        .STK_DO  (STK_DO),
        .STK_ENA (STK_ENA),
        .STK_RTS (STK_RTS),
        .STK_DI  (STK_DI)
    );

    // Simple LIFO memory answering the strobes.
    logic [AW-1:0] mem [0:15];
    logic [4:0]    sp;

    always @(posedge CLK2 or posedge RST) begin
        if (RST) begin
            sp <= 5'd0;
        end else if (STK_ENA && sp < 5'd16) begin
            mem[sp[3:0]] <= STK_DI;
            sp <= sp + 5'd1;
        end else if (STK_RTS && sp != 5'd0) begin
            sp <= sp - 5'd1;
        end
    end

    always_comb begin
        STK_DO = '0;
        if (sp != 5'd0)
            STK_DO = mem[sp[3:0] - 4'd1];
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    logic [AW-1:0] push_q[$];
    logic [AW-1:0] ret_q[$];
    int ena_cnt = 0;
    int rts_cnt = 0;

    always @(negedge CLK2) begin
        if (STK_ENA || STK_RTS)
            chk("ena_rts_excl", 32'(STK_ENA & STK_RTS), 32'd0);
        if (STK_ENA) begin
            ena_cnt++;
            if (push_q.size() == 0)
                chk("unexpected_push", 32'(STK_ENA), 32'd0);
            else
                chk("stk_di", 32'(STK_DI), 32'(push_q.pop_front()));
        end
        if (STK_RTS)
            rts_cnt++;
        if (bus.RET_VLD) begin
            if (ret_q.size() == 0)
                chk("unexpected_ret_vld", 32'(bus.RET_VLD), 32'd0);
            else
                chk("ret_addr", 32'(bus.RET_ADDR), 32'(ret_q.pop_front()));
        end
    end

    function automatic vec_t mk(input int k, input logic [AW-1:0] a,
                                input logic ack, input gnt_t g,
                                input logic [2:0] c, input logic e,
                                input logic [AW-1:0] r);
        vec_t v;
        v.kind = k; v.addr = a; v.exp_ack = ack; v.exp_gnt = g;
        v.exp_cnt = c; v.exp_err = e; v.exp_ret = r;
        return v;
    endfunction

    task automatic drop_all();
        bus.IRQ_REQ  = 1'b0;
        bus.RET_REQ  = 1'b0;
        bus.CALL_REQ = 1'b0;
    endtask

    task automatic do_reset();
        drop_all();
        bus.ERR_CLR = 1'b0;
        RST = 1'b1;
        repeat (2) @(negedge CLK2);
        RST = 1'b0;
        push_q.delete();
        ret_q.delete();
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int e0 = ena_cnt;
        int r0 = rts_cnt;
        int lat = 0;
        int exp_lat;
        exp_lat = !v.exp_ack ? 1 : (v.kind == 1 ? 3 : 2);
        if (v.exp_ack) begin
            if (v.kind == 1) ret_q.push_back(v.exp_ret);
            else             push_q.push_back(v.addr);
        end
        case (v.kind)
            0: begin bus.CALL_ADDR = v.addr; bus.CALL_REQ = 1'b1; end
            1: bus.RET_REQ = 1'b1;
            default: begin bus.IRQ_ADDR = v.addr; bus.IRQ_REQ = 1'b1; end
        endcase
        for (int c = 1; c <= 10; c++) begin
            @(posedge CLK2);
            @(negedge CLK2);
            if (bus.ACK || bus.NAK) begin
                lat = c;
                break;
            end
        end
        drop_all();
        chk({nm, ".latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, ".ack"}, 32'(bus.ACK), 32'(v.exp_ack));
        chk({nm, ".nak"}, 32'(bus.NAK), 32'(!v.exp_ack));
        chk({nm, ".gnt"}, 32'(bus.GNT), 32'(v.exp_gnt));
        chk({nm, ".depth"}, 32'(bus.DEPTH_CNT), 32'(v.exp_cnt));
        chk({nm, ".full"}, 32'(bus.FULL), 32'(v.exp_cnt == 3'd4));
        chk({nm, ".empty"}, 32'(bus.EMPTY), 32'(v.exp_cnt == 3'd0));
        chk({nm, ".err"}, 32'(bus.ERR), 32'(v.exp_err));
        @(negedge CLK2);
        @(posedge CLK2);
        chk({nm, ".ena_pulses"}, 32'(ena_cnt - e0),
            32'(v.exp_ack && v.kind != 1));
        chk({nm, ".rts_pulses"}, 32'(rts_cnt - r0),
            32'(v.exp_ack && v.kind == 1));
        @(negedge CLK2);
    endtask

    vec_t tbl [10];
    gnt_t exp_g [3];
    int   n_g;
    int   got;

    initial begin
        bus.IRQ_ADDR  = '0;
        bus.CALL_ADDR = '0;
        bus.ERR_CLR   = 1'b0;
        drop_all();
        RST = 1'b1;
        repeat (2) @(negedge CLK2);
        chk("rst.depth", 32'(bus.DEPTH_CNT), 32'd0);
        chk("rst.empty", 32'(bus.EMPTY), 32'd1);
        chk("rst.full", 32'(bus.FULL), 32'd0);
        chk("rst.err", 32'(bus.ERR), 32'd0);
        chk("rst.gnt", 32'(bus.GNT), 32'd0);
        chk("rst.ack_nak", 32'({bus.ACK, bus.NAK}), 32'd0);
        chk("rst.strobes", 32'({STK_ENA, STK_RTS, bus.RET_VLD}), 32'd0);
        chk("rst.stk_di", 32'(STK_DI), 32'd0);
        chk("rst.ret_addr", 32'(bus.RET_ADDR), 32'd0);
        RST = 1'b0;

        tbl[0] = mk(0, 20'h00123, 1, GNT_CALL, 3'd1, 0, 20'h0);
        tbl[1] = mk(0, 20'h00456, 1, GNT_CALL, 3'd2, 0, 20'h0);
        tbl[2] = mk(0, 20'h00789, 1, GNT_CALL, 3'd3, 0, 20'h0);
        tbl[3] = mk(0, 20'h00ABC, 1, GNT_CALL, 3'd4, 0, 20'h0);
        tbl[4] = mk(0, 20'h00DEF, 0, GNT_NONE, 3'd4, 1, 20'h0);
        tbl[5] = mk(1, 20'h0,     1, GNT_RET,  3'd3, 1, 20'h00ABC);
        tbl[6] = mk(1, 20'h0,     1, GNT_RET,  3'd2, 1, 20'h00789);
        tbl[7] = mk(1, 20'h0,     1, GNT_RET,  3'd1, 1, 20'h00456);
        tbl[8] = mk(1, 20'h0,     1, GNT_RET,  3'd0, 1, 20'h00123);
        tbl[9] = mk(1, 20'h0,     0, GNT_NONE, 3'd0, 1, 20'h0);
        for (int i = 0; i < 10; i++)
            run_vec(tbl[i], $sformatf("vec%0d", i));

        // Single entry pop, then underflow.
        do_reset();
        run_vec(mk(0, 20'h00ABC, 1, GNT_CALL, 3'd1, 0, 20'h0), "one.call");
        run_vec(mk(1, 20'h0, 1, GNT_RET, 3'd0, 0, 20'h00ABC), "one.ret");
        run_vec(mk(1, 20'h0, 0, GNT_NONE, 3'd0, 1, 20'h0), "one.under");

        // Clear racing a fresh underflow: the set wins.
        bus.RET_REQ = 1'b1;
        bus.ERR_CLR = 1'b1;
        @(posedge CLK2);
        @(negedge CLK2);
        chk("clr_race.nak", 32'(bus.NAK), 32'd1);
        chk("clr_race.err", 32'(bus.ERR), 32'd1);
        bus.RET_REQ = 1'b0;
        @(posedge CLK2);
        @(negedge CLK2);
        chk("clr_alone.err", 32'(bus.ERR), 32'd0);
        bus.ERR_CLR = 1'b0;

        // Reset landing in the middle of a pop.
        do_reset();
        run_vec(mk(0, 20'h00055, 1, GNT_CALL, 3'd1, 0, 20'h0), "mid.call");
        bus.RET_REQ = 1'b1;
        @(posedge CLK2);
        @(negedge CLK2);
        chk("mid.gnt_pop", 32'(bus.GNT), 32'(GNT_RET));
        #1 RST = 1'b1;
        #1;
        chk("mid.depth", 32'(bus.DEPTH_CNT), 32'd0);
        chk("mid.empty_full", 32'({bus.EMPTY, bus.FULL}), 32'b10);
        chk("mid.gnt", 32'(bus.GNT), 32'd0);
        chk("mid.pulses",
            32'({STK_ENA, STK_RTS, bus.ACK, bus.NAK, bus.RET_VLD}), 32'd0);
        chk("mid.data", 32'(STK_DI | bus.RET_ADDR), 32'd0);
        chk("mid.err", 32'(bus.ERR), 32'd0);
        bus.RET_REQ = 1'b0;
        @(negedge CLK2);
        RST = 1'b0;
        run_vec(mk(1, 20'h0, 0, GNT_NONE, 3'd0, 1, 20'h0), "mid.stale");

        // All three requesters at once.
        do_reset();
        run_vec(mk(0, 20'h00111, 1, GNT_CALL, 3'd1, 0, 20'h0), "arb.pre");
`ifdef STACK_CTRL_IRQ_EN
        exp_g[0] = GNT_IRQ; exp_g[1] = GNT_RET; exp_g[2] = GNT_CALL;
        n_g = 3;
        push_q.push_back(20'h002AA);
        ret_q.push_back(20'h002AA);
        push_q.push_back(20'h00333);
`else
        exp_g[0] = GNT_RET; exp_g[1] = GNT_CALL; exp_g[2] = GNT_NONE;
        n_g = 2;
        ret_q.push_back(20'h00111);
        push_q.push_back(20'h00333);
`endif
        bus.IRQ_ADDR  = 20'h002AA;
        bus.CALL_ADDR = 20'h00333;
        bus.IRQ_REQ   = 1'b1;
        bus.RET_REQ   = 1'b1;
        bus.CALL_REQ  = 1'b1;
        for (int k = 0; k < n_g; k++) begin
            got = 0;
            for (int c = 0; c < 10 && got == 0; c++) begin
                @(posedge CLK2);
                @(negedge CLK2);
                if (bus.ACK || bus.NAK) got = 1;
            end
            chk($sformatf("arb.gnt%0d", k), 32'(bus.GNT), 32'(exp_g[k]));
            chk($sformatf("arb.ack%0d", k), 32'(bus.ACK), 32'd1);
            case (bus.GNT)
                GNT_IRQ:  bus.IRQ_REQ  = 1'b0;
                GNT_RET:  bus.RET_REQ  = 1'b0;
                GNT_CALL: bus.CALL_REQ = 1'b0;
                default:  drop_all();
            endcase
        end
`ifndef STACK_CTRL_IRQ_EN
        for (int c = 0; c < 4; c++) begin
            @(posedge CLK2);
            @(negedge CLK2);
            chk("arb.irq_ignored", 32'({bus.GNT, bus.ACK, bus.NAK}), 32'd0);
        end
`endif
        drop_all();
        @(posedge CLK2);
        @(negedge CLK2);
`ifdef STACK_CTRL_IRQ_EN
        chk("arb.depth", 32'(bus.DEPTH_CNT), 32'd2);
`else
        chk("arb.depth", 32'(bus.DEPTH_CNT), 32'd1);
`endif
        chk("arb.push_q_drained", 32'(push_q.size()), 32'd0);
        chk("arb.ret_q_drained", 32'(ret_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
